// File: rtl/avalon_bus_arbiter.sv
// Two-master, one-slave Avalon-MM arbiter. Each transfer is granted atomically
// and held until the slave drops s_waitrequest; round-robin or fixed priority.
//
// state | meaning
// IDLE  | no owner, slave side quiet, both masters stalled
// GNT0  | master 0 owns the slave until its transfer completes or it withdraws
// GNT1  | master 1 owns the slave until its transfer completes or it withdraws
module avalon_bus_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0,
  parameter bit IDLE_ON_DONE   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [3:0]  m0_byteenable,
  input  logic [31:0] m0_writedata,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,

  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [3:0]  m1_byteenable,
  input  logic [31:0] m1_writedata,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,

  output logic [31:0] s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [3:0]  s_byteenable,
  output logic [31:0] s_writedata,
  input  logic        s_waitrequest,
  input  logic [31:0] s_readdata,

  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   req0, req1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // last_grant resets to 1 so that master 0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = (FIXED_PRIORITY || last_grant_q) ? GNT0 : GNT1;
        end else if (req0) begin
          state_d = GNT0;
        end else if (req1) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        // A withdrawn request ends the tenure without moving the pointer.
        if (!req0) begin
          state_d = IDLE;
        end else if (!s_waitrequest) begin
          last_grant_d = 1'b0;
          state_d      = (!IDLE_ON_DONE && req1) ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!req1) begin
          state_d = IDLE;
        end else if (!s_waitrequest) begin
          last_grant_d = 1'b1;
          state_d      = (!IDLE_ON_DONE && req0) ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_address      = 32'h0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_byteenable   = 4'h0;
    s_writedata    = 32'h0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    grant          = 2'b00;
    case (state_q)
      GNT0: begin
        s_address      = m0_address;
        s_read         = m0_read;
        s_write        = m0_write;
        s_byteenable   = m0_byteenable;
        s_writedata    = m0_writedata;
        m0_waitrequest = s_waitrequest;
        grant          = 2'b01;
      end
      GNT1: begin
        s_address      = m1_address;
        s_read         = m1_read;
        s_write        = m1_write;
        s_byteenable   = m1_byteenable;
        s_writedata    = m1_writedata;
        m1_waitrequest = s_waitrequest;
        grant          = 2'b10;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; only the owner in its done cycle looks at it.
  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

endmodule

// File: doc/avalon_bus_arbiter.md
Name: avalon_bus_arbiter

Overview:
- Two-master, one-slave Avalon-MM arbiter.
- Shares the single RAM_avalon slave between the CPU bus master (master 0) and a second master (master 1): a program loader, DMA engine or test driver.
- Each transfer is granted atomically and held until the slave accepts it.
- Grant policy is round-robin or fixed-priority, selected by parameter.

Parameters:
- FIXED_PRIORITY, 0: 0 = round-robin between masters; 1 = master 0 always wins simultaneous requests.
- IDLE_ON_DONE, 1: 1 = return to IDLE for one cycle after every completed transfer; 0 = allow a direct hand-over to the other waiting master.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous reset, active-low (reset==0 resets).
- m0_address  input  32  master 0 byte address.
- m0_read  input  1  master 0 read request.
- m0_write  input  1  master 0 write request.
- m0_byteenable  input  4  master 0 byte lanes.
- m0_writedata  input  32  master 0 write data.
- m0_waitrequest  output  1  stall to master 0.
- m0_readdata  output  32  read data to master 0.
- m1_*  same set and widths as m0_*, for master 1.
- s_address  output  32  to slave.
- s_read  output  1  to slave.
- s_write  output  1  to slave.
- s_byteenable  output  4  to slave.
- s_writedata  output  32  to slave.
- s_waitrequest  input  1  from slave.
- s_readdata  input  32  from slave.
- grant  output  2  one-hot current owner: 2'b01 = m0, 2'b10 = m1, 2'b00 = none.

Behaviour:
- States: IDLE, GNT0, GNT1. State is registered; all slave-side outputs are combinational from state.
- Pointer last_grant (1 bit) is registered.
- Reset (reset==0, async):
  - state=IDLE, last_grant=1 (m0 wins first tie).
  - s_read=0, s_write=0, s_address/s_byteenable/s_writedata=0.
  - m0_waitrequest=m1_waitrequest=1, grant=00.
- Request definition: reqX = mX_read | mX_write. A master asserting both read and write is a protocol error; it is forwarded as-is and not checked.
- IDLE:
  - Slave outputs are 0; both waitrequests are 1.
  - Only one master requesting: grant that master.
  - Both requesting, FIXED_PRIORITY=1: grant m0.
  - Both requesting, FIXED_PRIORITY=0: grant the master != last_grant.
  - The transition occurs at the next clock edge. Arbitration latency is exactly 1 cycle from request to s_read/s_write.
- GNTx:
  - Slave outputs equal master x's signals.
  - mX_waitrequest = s_waitrequest; the other master's waitrequest = 1.
  - grant reflects x.
- Done = reqX & !s_waitrequest in GNTx. The transfer completes in that cycle.
- On the edge after done: last_grant=x.
  - IDLE_ON_DONE=1: next=IDLE.
  - IDLE_ON_DONE=0: next=GNT(other) if the other master is requesting, else IDLE.
- Master x deasserts its request while granted and not done: next=IDLE, no transfer is counted, and last_grant is unchanged.
- m0_readdata = m1_readdata = s_readdata at all times (broadcast). It is only meaningful to the granted master in its done cycle.
- No preemption: a granted master keeps the slave however long s_waitrequest stays high.
- Asynchronous reset mid-transfer: outputs return to their reset values immediately; an in-flight slave access is abandoned.
- grant is never 2'b11, and s_read/s_write are never driven in IDLE.

Test Plan:
- Single read from m0:
  - Stimulus: m0_read=1, m0_address=0x1000; slave waitrequest=1 for 2 cycles, then 0 with s_readdata=0xDEADBEEF.
  - Response: s_read rises 1 cycle after the request; grant=01; m0_waitrequest follows slave; m0 samples 0xDEADBEEF; state IDLE on the next edge.
- Simultaneous requests, round-robin:
  - Stimulus: m0 write 0x10 and m1 read 0x20 held continuously for 4 transfers.
  - Response: grant order m0, m1, m0, m1; m1_waitrequest=1 throughout every m0 transfer.
- Simultaneous requests, FIXED_PRIORITY=1:
  - Stimulus: both masters request continuously.
  - Response: m0 is granted every time; m1 is granted only when m0 drops its request.
- Write pass-through:
  - Stimulus: m1_write=1, m1_byteenable=4'b0011, m1_writedata=0x0000ABCD, slave with 0-wait.
  - Response: s_byteenable=0011 and s_writedata=0x0000ABCD for one cycle; m1_waitrequest=0 that cycle.
- IDLE_ON_DONE=0 hand-over:
  - Stimulus: both requesting, slave with 0-wait.
  - Response: no IDLE cycle between transfers; grant alternates 01/10 every cycle.
- Reset mid-transfer:
  - Stimulus: pull reset low while in GNT0 with s_waitrequest=1.
  - Response: immediately s_read=0, grant=00, both waitrequest=1; after release, m0 wins the first tie.
